display_scan_scheduler: RTL and testbench
=========================================

// Module: display_scan_scheduler
// PURPOSE
//   Time-multiplexes one shared seven-segment bus (Seg/Dp) across NUM_DIGITS anodes.
//   Advances round-robin on each rising edge of RefreshClk, the ~381 Hz square wave from the clock divider.
//   Skips disabled digits and inserts a fixed blanking gap between digits to prevent ghosting.
//   Sits between the clock divider and the board display pins; digit data comes from the counter/datapath logic.
// PARAMETERS
//   NUM_DIGITS    4   number of multiplexed digits (2..8)
//   BLANK_CYCLES  16  Clk cycles with all anodes off between digits (>=1, < RefreshClk period)
// PORTS
//   Clk          in   1              system clock
//   Reset        in   1              asynchronous, active-high reset
//   RefreshClk   in   1              divider square wave; derived from Clk, no synchroniser needed
//   DigitEnable  in   NUM_DIGITS     1 = digit takes part in the scan
//   DigitData    in   4*NUM_DIGITS   hex code per digit; digit i = [4i+3:4i]
//   DpIn         in   NUM_DIGITS     decimal point per digit, 1 = lit
//   An           out  NUM_DIGITS     anode selects, active-low
//   Seg          out  7              segments {g,f,e,d,c,b,a}, active-low
//   Dp           out  1              decimal point, active-low
//   ActiveDigit  out  clog2(N)       index of the last selected digit
//   FrameDone    out  1              1-cycle pulse when the scan wraps
// BEHAVIOUR
//   Reset values (async): state=IDLE, An=all 1, Seg=7'h7F, Dp=1, ActiveDigit=NUM_DIGITS-1, FrameDone=0,
//     refresh_q=1 (a high RefreshClk at reset release is NOT treated as an edge).
//   Edge event: rise = RefreshClk & ~refresh_q; refresh_q <= RefreshClk every cycle.
//   All outputs are registered and change only on Clk edges.
//   FSM states: IDLE, BLANK, SHOW.
//   Next-digit search on rise:
//     - Scan starts at ActiveDigit+1 (mod NUM_DIGITS), goes round-robin, ActiveDigit itself last.
//     - Take the first index with DigitEnable=1.
//     - If none found: go to / stay in IDLE.
//   IDLE or SHOW + rise, enabled digit found:
//     - Go to BLANK; latch the index into ActiveDigit; load the blank counter.
//     - An=all 1 from the edge that samples the rise.
//   BLANK:
//     - Outputs blank (An all 1, Seg 7'h7F, Dp 1).
//     - After BLANK_CYCLES cycles go to SHOW.
//     - A rise during BLANK is ignored (dropped).
//   BLANK->SHOW:
//     - An[ActiveDigit]=0; FrameDone=1 for that one cycle if new index <= previous shown index.
//     - This includes the single-digit case and the first show after reset.
//   SHOW:
//     - Seg = decode(DigitData[ActiveDigit]), Dp = ~DpIn[ActiveDigit].
//     - Data is live: 1-cycle latency from input change to output.
//   SHOW with DigitEnable[ActiveDigit]=0:
//     - Next cycle go to IDLE with all outputs blanked.
//     - Next rise re-searches from ActiveDigit+1.
//   Decode 0-F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex, {g..a}).
//   Reset mid-operation: immediate return to reset values; the scan restarts at digit 0.
//   Blank counter width = clog2(BLANK_CYCLES+1); it never wraps.
// TESTING
//   1. Reset asserted, then released with RefreshClk=1 -> An=4'hF, Seg=7'h7F, Dp=1, ActiveDigit=3,
//      no transition until the next RefreshClk rise.
//   2. Enable=4'hF, Data=16'h1234, DpIn=4'b0001, RefreshClk period 64 cycles:
//      - An cycles 1110(Seg 19, Dp 0), 1101(30), 1011(24), 0111(79), then repeats.
//      - 16 blank cycles precede each digit.
//      - FrameDone pulses only on entry to digit 0.
//   3. Enable=4'b1010 -> only 1101/0111 alternate; FrameDone on every entry to digit 1;
//      digits 0 and 2 are never driven.
//   4. Enable=4'h0 -> An stays 4'hF across 5 rises; set Enable=4'b0100 -> after the next rise
//      plus 16 cycles, An=1011.
//   5. In SHOW on digit 2, clear Enable[2] -> the next cycle An=4'hF, Seg=7'h7F;
//      a rise in mid-BLANK is ignored and the next digit shows after BLANK_CYCLES.
//   6. Assert Reset during BLANK -> outputs take reset values the same cycle;
//      after release the first shown digit is 0, with FrameDone=1.

Source files
------------

// File: rtl/display_scan_scheduler_if.sv
// Display scan scheduler bundle: per-digit data
// in from the datapath, multiplexed pins out.
interface display_scan_scheduler_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS-1:0]   DigitEnable;
  logic [4*NUM_DIGITS-1:0] DigitData;
  logic [NUM_DIGITS-1:0]   DpIn;
  logic [NUM_DIGITS-1:0]   An;
  logic [6:0]              Seg;
  logic                    Dp;
  logic [AW-1:0]           ActiveDigit;
  logic                    FrameDone;

  modport master (
    output DigitEnable, DigitData, DpIn,
    input  An, Seg, Dp, ActiveDigit, FrameDone
  );

  modport slave (
    input  DigitEnable, DigitData, DpIn,
    output An, Seg, Dp, ActiveDigit, FrameDone
  );
endinterface

// File: rtl/display_scan_scheduler.sv
// Round-robin seven-segment scan with blanking
// gap between digits, stepped by RefreshClk rises.
module display_scan_scheduler #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input logic Clk,
  input logic Reset,
  input logic RefreshClk,
  display_scan_scheduler_if.slave bus
);
  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(BLANK_CYCLES + 1);
  localparam logic [AW-1:0] LAST = AW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] act_q, act_d;
  logic [AW-1:0] prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic refresh_q;
  logic rise;
  logic found;
  logic [AW-1:0] nxt;
  logic [AW-1:0] cand;
  logic [3:0] hex [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic fd_q, fd_d;

  function automatic logic [6:0] decode(
    input logic [3:0] h
  );
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hex
    assign hex[gi] = bus.DigitData[4*gi +: 4];
  end

  assign rise = RefreshClk & ~refresh_q;

  // Find the first enabled digit after the current one,
  // wrapping round so the current digit is tried last.
  always_comb begin
    found = 1'b0;
    nxt   = act_q;
    cand  = '0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      cand = AW'((int'(act_q) + k) % NUM_DIGITS);
      if (!found && bus.DigitEnable[cand]) begin
        found = 1'b1;
        nxt   = cand;
      end
    end
  end

  // Next state: rises are only honoured outside BLANK.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rise && found) begin
          state_d = BLANK;
          prev_d  = act_q;
          act_d   = nxt;
          cnt_d   = CW'(BLANK_CYCLES);
        end
      end
      BLANK: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (rise) begin
          if (found) begin
            state_d = BLANK;
            prev_d  = act_q;
            act_d   = nxt;
            cnt_d   = CW'(BLANK_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.DigitEnable[act_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the coming cycle; blank unless showing.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    fd_d  = 1'b0;
    if (state_d == SHOW) begin
      an_d  = ~(NUM_DIGITS'(1) << act_d);
      seg_d = decode(hex[act_d]);
      dp_d  = ~bus.DpIn[act_d];
    end
    if (state_q == BLANK && state_d == SHOW) begin
      fd_d = (act_q <= prev_q);
    end
  end

  // State, edge detector and registered pins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      act_q     <= LAST;
      prev_q    <= LAST;
      cnt_q     <= '0;
      refresh_q <= 1'b1;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      refresh_q <= RefreshClk;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.An          = an_q;
  assign bus.Seg         = seg_q;
  assign bus.Dp          = dp_q;
  assign bus.ActiveDigit = act_q;
  assign bus.FrameDone   = fd_q;
endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: directed scan
// scenarios plus random stimulus against a timing model.
module tb_display_scan_scheduler;
  localparam int N = 4;
  localparam int B = 16;

  logic Clk = 1'b0;
  logic Reset;
  logic RefreshClk;

  display_scan_scheduler_if #(.NUM_DIGITS(N)) bus ();

  display_scan_scheduler #(
    .NUM_DIGITS(N),
    .BLANK_CYCLES(B)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .RefreshClk(RefreshClk),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  int passed = 0;
  int total = 0;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [3:0] AN2 [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  localparam logic [6:0] SG2 [4] = '{7'h30, 7'h24, 7'h79, 7'h19};
  localparam logic       DP2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic       FD2 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [3:0] AN3 [4] = '{4'b1101, 4'b0111, 4'b1101, 4'b0111};
  localparam logic       FD3 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic int next_en(input int c,
                                 input logic [N-1:0] en);
    for (int k = 1; k <= N; k++) begin
      if (en[(c + k) % N]) return (c + k) % N;
    end
    return -1;
  endfunction

  // Timing model: a digit accepted on edge n is dark until
  // edge n+B, then lit until the next accepted/failed rise.
  initial begin
    int n, show_at, cur, prev, f;
    bit act, prc, rise, vis, e_fd;
    logic [N-1:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    logic [3:0] dg;
    n = 0; show_at = 0; cur = N - 1; prev = N - 1;
    act = 0; prc = 1;
    forever begin
      @(posedge Clk);
      n++;
      vis = 0;
      e_fd = 0;
      if (Reset) begin
        act = 0; cur = N - 1; prev = N - 1; prc = 1;
      end else begin
        rise = RefreshClk && !prc;
        prc = RefreshClk;
        f = next_en(cur, bus.DigitEnable);
        if (!act) begin
          if (rise && f >= 0) begin
            act = 1; prev = cur; cur = f; show_at = n + B;
          end
        end else if (n < show_at) begin
          vis = 0;
        end else if (n == show_at) begin
          vis = 1;
          e_fd = (cur <= prev);
        end else if (rise) begin
          if (f >= 0) begin
            prev = cur; cur = f; show_at = n + B;
          end else begin
            act = 0;
          end
        end else if (!bus.DigitEnable[cur]) begin
          act = 0;
        end else begin
          vis = 1;
        end
      end
      dg = 4'(bus.DigitData >> (4 * cur));
      e_an = vis ? ~(N'(1) << cur) : '1;
      e_seg = vis ? seg_tab[dg] : 7'h7F;
      e_dp = vis ? ~bus.DpIn[cur] : 1'b1;
      #1;
      check("cycle",
            32'({bus.An, bus.Seg, bus.Dp, bus.ActiveDigit, bus.FrameDone}),
            32'({e_an, e_seg, e_dp, 2'(cur), e_fd}));
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  task automatic gen_rise();
    @(negedge Clk) RefreshClk = 1'b0;
    repeat (31) @(negedge Clk);
    RefreshClk = 1'b1;
  endtask

  initial begin
    int hp;
    Reset = 1'b1;
    RefreshClk = 1'b1;
    bus.DigitEnable = 4'hF;
    bus.DigitData = 16'h1234;
    bus.DpIn = 4'b0001;

    // reset values
    step(3);
    check("rst_an", 32'(bus.An), 32'hF);
    check("rst_seg", 32'(bus.Seg), 32'h7F);
    check("rst_dp", 32'(bus.Dp), 32'h1);
    check("rst_ad", 32'(bus.ActiveDigit), 32'h3);
    check("rst_fd", 32'(bus.FrameDone), 32'h0);
    @(negedge Clk) Reset = 1'b0;
    step(6);
    check("rel_an", 32'(bus.An), 32'hF);
    check("rel_ad", 32'(bus.ActiveDigit), 32'h3);

    // full scan of four digits
    gen_rise();
    step(16);
    check("t2_blank", 32'(bus.An), 32'hF);
    step(1);
    check("t2_an0", 32'(bus.An), 32'hE);
    check("t2_seg0", 32'(bus.Seg), 32'h19);
    check("t2_dp0", 32'(bus.Dp), 32'h0);
    check("t2_fd0", 32'(bus.FrameDone), 32'h1);
    step(1);
    check("t2_fdoff", 32'(bus.FrameDone), 32'h0);
    for (int i = 0; i < 4; i++) begin
      gen_rise();
      step(17);
      check("t2_an", 32'(bus.An), 32'(AN2[i]));
      check("t2_seg", 32'(bus.Seg), 32'(SG2[i]));
      check("t2_dp", 32'(bus.Dp), 32'(DP2[i]));
      check("t2_fd", 32'(bus.FrameDone), 32'(FD2[i]));
    end

    // two enabled digits
    @(negedge Clk) bus.DigitEnable = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      gen_rise();
      step(17);
      check("t3_an", 32'(bus.An), 32'(AN3[i]));
      check("t3_fd", 32'(bus.FrameDone), 32'(FD3[i]));
    end

    // nothing enabled, then one digit
    @(negedge Clk) bus.DigitEnable = 4'h0;
    for (int i = 0; i < 5; i++) begin
      gen_rise();
      step(17);
      check("t4_dark", 32'(bus.An), 32'hF);
    end
    @(negedge Clk) bus.DigitEnable = 4'b0100;
    gen_rise();
    step(16);
    check("t4_blank", 32'(bus.An), 32'hF);
    step(1);
    check("t4_an", 32'(bus.An), 32'hB);
    check("t4_seg", 32'(bus.Seg), 32'h24);
    check("t4_fd", 32'(bus.FrameDone), 32'h1);

    // disable while showing, rise during blank
    @(negedge Clk) bus.DigitEnable = 4'h0;
    step(1);
    check("t5_an_off", 32'(bus.An), 32'hF);
    check("t5_seg_off", 32'(bus.Seg), 32'h7F);
    @(negedge Clk) bus.DigitEnable = 4'b1000;
    gen_rise();
    step(1);
    @(negedge Clk) RefreshClk = 1'b0;
    @(negedge Clk) RefreshClk = 1'b1;
    step(14);
    check("t5_blank", 32'(bus.An), 32'hF);
    step(1);
    check("t5_an", 32'(bus.An), 32'h7);
    check("t5_ad", 32'(bus.ActiveDigit), 32'h3);
    check("t5_fd", 32'(bus.FrameDone), 32'h0);

    // reset during blank
    @(negedge Clk) bus.DigitEnable = 4'hF;
    gen_rise();
    step(5);
    @(negedge Clk) Reset = 1'b1;
    #1;
    check("t6_an", 32'(bus.An), 32'hF);
    check("t6_ad", 32'(bus.ActiveDigit), 32'h3);
    check("t6_seg", 32'(bus.Seg), 32'h7F);
    step(2);
    @(negedge Clk) Reset = 1'b0;
    gen_rise();
    step(17);
    check("t6_an0", 32'(bus.An), 32'hE);
    check("t6_fd", 32'(bus.FrameDone), 32'h1);
    check("t6_ad0", 32'(bus.ActiveDigit), 32'h0);

    // random traffic
    hp = 5;
    for (int c = 0; c < 5000; c++) begin
      @(negedge Clk);
      if (hp == 0) begin
        RefreshClk = ~RefreshClk;
        hp = int'($urandom_range(2, 40));
      end else begin
        hp--;
      end
      if ($urandom_range(0, 49) == 0)
        bus.DigitEnable = 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        bus.DigitData = 16'($urandom);
      if ($urandom_range(0, 15) == 0)
        bus.DpIn = 4'($urandom);
      Reset = ($urandom_range(0, 999) == 0);
    end
    @(negedge Clk) Reset = 1'b0;
    step(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
